// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: per-channel synchroniser, debounce filter,
// registered press/release pulses and an optional auto-repeat strobe.
module btn_conditioner #(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_RATE     = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N_CH-1:0] btn_raw_i,
    output logic [N_CH-1:0] btn_level_o,
    output logic [N_CH-1:0] btn_rise_o,
    output logic [N_CH-1:0] btn_fall_o,
    output logic [N_CH-1:0] btn_repeat_o
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_TC    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [RPT_W-1:0] DELAY_TC = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RATE_TC  = RPT_W'(REPEAT_RATE);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= btn_raw_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic             sync_val;
        logic             stable_q, stable_d;
        logic [DB_W-1:0]  db_cnt_q, db_cnt_d, db_inc;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;
        logic             rpt_q, rpt_d;
        rpt_state_e       state_q, state_d;
        logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc;

        assign sync_val = sync_q[SYNC_STAGES-1][ch];
        assign db_inc   = db_cnt_q + DB_W'(1);
        assign rpt_inc  = rpt_cnt_q + RPT_W'(1);

        always_comb begin
            stable_d = stable_q;
            db_cnt_d = '0;
            if (sync_val != stable_q) begin
                if (db_inc == DB_TC) begin
                    stable_d = ~stable_q;
                end else begin
                    db_cnt_d = db_inc;
                end
            end
            rise_d = stable_d & ~stable_q;
            fall_d = ~stable_d & stable_q;
        end

        // Decisions use the next level so pulses line up with the level change.
        always_comb begin
            state_d   = state_q;
            rpt_cnt_d = rpt_cnt_q;
            rpt_d     = 1'b0;
            if (!stable_d) begin
                state_d   = RPT_IDLE;
                rpt_cnt_d = '0;
            end else begin
                case (state_q)
                    RPT_IDLE: begin
                        rpt_d = rise_d;
                        if (rise_d && (REPEAT_DELAY != 0)) begin
                            state_d   = RPT_DELAY;
                            rpt_cnt_d = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (rpt_inc == DELAY_TC) begin
                            rpt_d     = 1'b1;
                            rpt_cnt_d = '0;
                            state_d   = RPT_REPEAT;
                        end else begin
                            rpt_cnt_d = rpt_inc;
                        end
                    end
                    RPT_REPEAT: begin
                        if (rpt_inc == RATE_TC) begin
                            rpt_d     = 1'b1;
                            rpt_cnt_d = '0;
                        end else begin
                            rpt_cnt_d = rpt_inc;
                        end
                    end
                    default: begin
                        state_d   = RPT_IDLE;
                        rpt_cnt_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                stable_q  <= 1'b0;
                db_cnt_q  <= '0;
                rise_q    <= 1'b0;
                fall_q    <= 1'b0;
                rpt_q     <= 1'b0;
                state_q   <= RPT_IDLE;
                rpt_cnt_q <= '0;
            end else begin
                stable_q  <= stable_d;
                db_cnt_q  <= db_cnt_d;
                rise_q    <= rise_d;
                fall_q    <= fall_d;
                rpt_q     <= rpt_d;
                state_q   <= state_d;
                rpt_cnt_q <= rpt_cnt_d;
            end
        end

        assign btn_level_o[ch]  = stable_q;
        assign btn_rise_o[ch]   = rise_q;
        assign btn_fall_o[ch]   = fall_q;
        assign btn_repeat_o[ch] = rpt_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random button activity,
// compared every cycle against a windowed reference model of the conditioner.
module tb_btn_conditioner;
    localparam int N  = 2;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RR = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] raw;
    logic [N-1:0] lvl_o, rise_o, fall_o, rep_o;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk_i(clk), .reset_i(rst), .btn_raw_i(raw),
        .btn_level_o(lvl_o), .btn_rise_o(rise_o),
        .btn_fall_o(fall_o), .btn_repeat_o(rep_o)
    );

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    // Reference: raw captures per edge; level takes a new value once the last DB
    // synchronised samples (raw delayed SS edges) all disagree with it.
    bit           m_cap[N][$];
    int           m_t[N];
    logic [N-1:0] m_lvl, m_rise, m_fall, m_rep;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, ecount, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) begin
            m_cap[ch].delete();
            for (int i = 0; i < SS + DB; i++) m_cap[ch].push_back(1'b0);
            m_t[ch] = 0;
        end
        m_lvl = '0; m_rise = '0; m_fall = '0; m_rep = '0;
    endtask

    task automatic model_edge();
        logic old;
        bit   flip;
        int   d;
        ecount++;
        if (rst) begin
            model_reset();
            return;
        end
        for (int ch = 0; ch < N; ch++) begin
            old  = m_lvl[ch];
            flip = 1'b1;
            for (int i = 1; i <= DB; i++) if (m_cap[ch][i] == old) flip = 1'b0;
            m_cap[ch].push_back(raw[ch]);
            void'(m_cap[ch].pop_front());
            m_lvl[ch]  = flip ? ~old : old;
            m_rise[ch] = m_lvl[ch] & ~old;
            m_fall[ch] = ~m_lvl[ch] & old;
            if (m_rise[ch]) m_t[ch] = ecount;
            d = ecount - m_t[ch];
            m_rep[ch] = m_lvl[ch] &&
                        (d == 0 || d == RD || (d > RD && ((d - RD) % RR) == 0));
        end
    endtask

    task automatic check_all();
        chk("level", lvl_o, m_lvl);
        chk("rise", rise_o, m_rise);
        chk("fall", fall_o, m_fall);
        chk("repeat", rep_o, m_rep);
    endtask

    task automatic step(input logic [N-1:0] r);
        raw = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [N-1:0] cur;
        int           hold[N];

        rst = 1'b1;
        raw = '0;
        model_reset();
        #2;
        chk("reset_level", lvl_o, '0);
        chk("reset_pulses", rise_o | fall_o | rep_o, '0);
        step(2'b00);
        step(2'b00);
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) step(2'b00);

        // Clean press on channel 0; first capturing edge is k=0
        for (int k = 0; k < 10; k++) begin
            step(2'b01);
            if (k == 5) begin
                chk("press_edge5_rise", rise_o, 2'b01);
                chk("press_edge5_rep", rep_o, 2'b01);
            end
            if (k == 4) chk("press_edge4_level", lvl_o, 2'b00);
        end
        for (int k = 0; k < 8; k++) step(2'b00);

        // Glitch on channel 1 shorter than the debounce window
        for (int k = 0; k < 3; k++) step(2'b10);
        for (int k = 0; k < 10; k++) begin
            step(2'b00);
            chk("glitch_level1", lvl_o & 2'b10, 2'b00);
        end

        // Bounce on channel 0 then hold
        step(2'b01); step(2'b00); step(2'b01); step(2'b00);
        for (int k = 0; k < 8; k++) begin
            step(2'b01);
            if (k == 5) chk("bounce_rise", rise_o, 2'b01);
        end

        // Long hold for auto-repeat, then release
        for (int k = 0; k < 30; k++) step(2'b01);
        for (int k = 0; k < 12; k++) step(2'b00);

        // Async reset in the REPEAT phase, released with the button held
        for (int k = 0; k < 20; k++) step(2'b01);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_level", lvl_o, '0);
        chk("async_rst_pulses", rise_o | fall_o | rep_o, '0);
        model_reset();
        step(2'b01);
        step(2'b01);
        #2 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(2'b01);
            if (k == 5) chk("post_rst_rise", rise_o, 2'b01);
        end
        for (int k = 0; k < 10; k++) step(2'b00);

        // Independence: channels pressed two cycles apart
        step(2'b01);
        step(2'b01);
        for (int k = 0; k < 12; k++) step(2'b11);
        for (int k = 0; k < 10; k++) step(2'b00);

        // Random activity with varied hold lengths
        cur = '0;
        for (int ch = 0; ch < N; ch++) hold[ch] = 0;
        for (int k = 0; k < 500; k++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (hold[ch] == 0) begin
                    cur[ch]  = 1'($urandom_range(0, 1));
                    hold[ch] = $urandom_range(1, (($urandom_range(0, 3) == 0) ? 30 : 7));
                end
                hold[ch]--;
            end
            step(cur);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Parametrised multi-channel push-button conditioner; the next generation of the single-channel button edge detector. Each of N_CH raw, asynchronous button inputs passes through a synchroniser and a debounce filter. The block then produces a clean level, one-cycle press and release pulses, and an optional auto-repeat strobe. It sits between the board pins and the control FSMs, so those FSMs consume single-cycle strobes only.

## Interface
- N_CH, 4: number of independent button channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, 16: consecutive cycles a new synchronised value must hold before it is accepted (≥1).
- REPEAT_DELAY, 0: cycles from the press pulse to the first repeat pulse; 0 disables auto-repeat.
- REPEAT_RATE, 1: cycles between subsequent repeat pulses (≥1; ignored when REPEAT_DELAY=0).
- clk  in  1  single system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- btn_raw  in  N_CH  raw button pins, asynchronous to clk, active-high.
- btn_level  out  N_CH  debounced, synchronised level.
- btn_rise  out  N_CH  one-cycle pulse when btn_level goes 0→1.
- btn_fall  out  N_CH  one-cycle pulse when btn_level goes 1→0.
- btn_repeat  out  N_CH  press pulse plus auto-repeat strobes.

## Operation
- Channels are fully independent; per channel:
  - sync chain
  - debounce counter of width $clog2(DEBOUNCE_CYCLES+1)
  - stable register (drives btn_level)
  - repeat counter of width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)
- Synchroniser: btn_raw shifts through SYNC_STAGES flops; the last stage is the sync value.
- Debounce:
  - If sync == stable, the counter clears to 0.
  - Otherwise the counter increments.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, stable toggles and the counter clears.
  - A mismatch run shorter than DEBOUNCE_CYCLES never changes stable.
- Edge pulses are registered:
  - btn_rise=1 exactly in the first cycle btn_level reads 1.
  - btn_fall=1 exactly in the first cycle btn_level reads 0.
  - A channel never has both asserted in the same cycle.
- Auto-repeat, per channel, with states IDLE → DELAY → REPEAT:
  - IDLE: btn_repeat mirrors btn_rise. A rise moves to DELAY with the counter at 0.
  - DELAY: the counter increments while btn_level=1. At count REPEAT_DELAY, pulse btn_repeat, clear the counter and go to REPEAT.
  - REPEAT: at count REPEAT_RATE, pulse and clear the counter.
  - btn_level=0 in any state returns to IDLE, clears the counter and emits no pulse that cycle.
  - REPEAT_DELAY=0: the FSM stays in IDLE and btn_repeat == btn_rise.
- Reset (asynchronous, any time, including mid-debounce or mid-repeat):
  - All sync flops, counters and stable registers go to 0; the FSM goes to IDLE.
  - btn_level, btn_rise, btn_fall and btn_repeat are 0 while reset is high.
- After reset release, a button already held is treated as a new press. It goes through the full latency and generates btn_rise.

## Timing
- Press/release latency: btn_raw changes before posedge E0 and then holds. btn_level changes at posedge E0 + (SYNC_STAGES + DEBOUNCE_CYCLES − 1).
- btn_rise, btn_fall and the first btn_repeat are coincident with that btn_level change (0 additional cycles).
- Repeat pulses fall at T, T+REPEAT_DELAY, T+REPEAT_DELAY+REPEAT_RATE, T+REPEAT_DELAY+2·REPEAT_RATE, …, where T is the btn_rise cycle. They continue while btn_level stays 1.
- Pulses are always exactly one cycle wide.
- Input bounce within DEBOUNCE_CYCLES of a change restarts the count: latency is measured from the last raw change.
- No combinational path from btn_raw to any output.

## Test plan
Bench parameters: N_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3.
- Reset then clean press: btn_raw[0] 0→1 before edge 0 and held. btn_level[0] rises at edge 5, btn_rise[0]=1 for one cycle at edge 5, btn_repeat[0]=1 at edge 5; channel 1 stays 0 throughout.
- Glitch rejection: btn_raw[1] high for 3 cycles, then low. btn_level[1], btn_rise[1] and btn_repeat[1] stay 0.
- Bounce: btn_raw[0] toggles 1,0,1,0,1 on successive cycles, then holds 1. btn_level[0] rises 5 edges after the last 0→1; exactly one btn_rise.
- Auto-repeat: hold btn_raw[0] for 30 cycles after rise at T. btn_repeat[0] pulses at T, T+8, T+11, T+14, …. On release, btn_fall[0] pulses 5 edges after the raw fall and repeat pulses stop.
- Async reset mid-repeat: assert reset between clock edges while in REPEAT. All outputs drop to 0 immediately, before the next edge. Release reset with btn_raw[0] still 1: btn_rise[0] fires 5 edges later.
- Independence: press both channels 2 cycles apart. Each channel's btn_rise occurs at its own latency, with no cross-channel effect.
